// File: rtl/canvas_ctrl.sv
// rtl/canvas_ctrl.sv - 14x14 drawing canvas sequencer: cursor-to-cell mapping, paint, clear, NN hand-off
module canvas_ctrl #(
    parameter int X0     = 90,
    parameter int Y0     = 34,
    parameter int CELL_W = 10,
    parameter int CELL_H = 14,
    parameter int GRID   = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8:0]             mouse_x,
    input  logic [8:0]             mouse_y,
    input  logic                   left_btn,
    input  logic                   clear_btn,
    input  logic                   submit_btn,
    input  logic                   nn_ready,
    input  logic                   nn_done,
    input  logic [3:0]             nn_digit,
    output logic [GRID*GRID-1:0]   img,
    output logic                   img_valid,
    output logic                   busy,
    output logic [3:0]             digit_out,
    output logic                   digit_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAP   = 3'd1;
    localparam logic [2:0] S_PAINT = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [8:0] X_LO = 9'(X0);
    localparam logic [8:0] X_HI = 9'(X0 + GRID * CELL_W);
    localparam logic [8:0] Y_LO = 9'(Y0);
    localparam logic [8:0] Y_HI = 9'(Y0 + GRID * CELL_H);
    localparam logic [8:0] CW   = 9'(CELL_W);
    localparam logic [8:0] CH   = 9'(CELL_H);

    logic [2:0] state;
    logic       clear_q;
    logic       submit_q;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [3:0] col;
    logic [3:0] row;
    logic       clear_rise;
    logic       submit_rise;
    logic       in_window;
    logic [7:0] cell_idx;

    assign clear_rise  = clear_btn & ~clear_q;
    assign submit_rise = submit_btn & ~submit_q;
    // Compare against both bounds before any subtraction so off-grid cursors never wrap.
    assign in_window   = (mouse_x >= X_LO) && (mouse_x < X_HI) &&
                         (mouse_y >= Y_LO) && (mouse_y < Y_HI);
    assign cell_idx    = 8'(row) * 8'(GRID) + 8'(col);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            img         <= '0;
            img_valid   <= 1'b0;
            digit_out   <= 4'd0;
            digit_valid <= 1'b0;
            clear_q     <= 1'b0;
            submit_q    <= 1'b0;
            dx          <= 9'd0;
            dy          <= 9'd0;
            col         <= 4'd0;
            row         <= 4'd0;
        end else begin
            clear_q  <= clear_btn;
            submit_q <= submit_btn;
            case (state)
                S_IDLE: begin
                    if (clear_rise) begin
                        img         <= '0;
                        digit_valid <= 1'b0;
                    end else if (submit_rise) begin
                        digit_valid <= 1'b0;
                        img_valid   <= 1'b1;
                        state       <= S_SEND;
                    end else if (left_btn && in_window) begin
                        dx    <= mouse_x - X_LO;
                        dy    <= mouse_y - Y_LO;
                        col   <= 4'd0;
                        row   <= 4'd0;
                        state <= S_MAP;
                    end
                end
                S_MAP: begin
                    // Repeated subtraction: x and y quotients advance in parallel, one step per cycle.
                    if (dx < CW && dy < CH) begin
                        state <= S_PAINT;
                    end else begin
                        if (dx >= CW) begin
                            dx  <= dx - CW;
                            col <= col + 4'd1;
                        end
                        if (dy >= CH) begin
                            dy  <= dy - CH;
                            row <= row + 4'd1;
                        end
                    end
                end
                S_PAINT: begin
                    img[cell_idx] <= 1'b1;
                    state         <= S_IDLE;
                end
                S_SEND: begin
                    if (nn_ready) begin
                        img_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (nn_done) begin
                        digit_out   <= nn_digit;
                        digit_valid <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_canvas_ctrl.sv
// tb/tb_canvas_ctrl.sv - randomized self-checking bench for canvas_ctrl against a cell-level canvas model
module tb_canvas_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [8:0]   mouse_x;
    logic [8:0]   mouse_y;
    logic         left_btn;
    logic         clear_btn;
    logic         submit_btn;
    logic         nn_ready;
    logic         nn_done;
    logic [3:0]   nn_digit;
    logic [195:0] img;
    logic         img_valid;
    logic         busy;
    logic [3:0]   digit_out;
    logic         digit_valid;

    logic [195:0] model_img;
    logic [3:0]   model_digit;
    logic         model_dvalid;
    int           n_checks = 0;
    int           n_fail   = 0;

    canvas_ctrl dut (
        .clk(clk), .reset(reset), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .left_btn(left_btn), .clear_btn(clear_btn), .submit_btn(submit_btn),
        .nn_ready(nn_ready), .nn_done(nn_done), .nn_digit(nn_digit),
        .img(img), .img_valid(img_valid), .busy(busy),
        .digit_out(digit_out), .digit_valid(digit_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [195:0] obs, input logic [195:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle click; model derives the cell with plain division and expects
    // k+2 busy cycles and the bit visible on edge k+3 counting the sample edge as 1.
    task automatic click(input int x, input int y);
        int  col, row, k, idx, n_busy, edges, lat;
        bit  inw, new_bit;
        inw = (x >= 90) && (x < 230) && (y >= 34) && (y < 230);
        mouse_x  = 9'(x);
        mouse_y  = 9'(y);
        left_btn = 1'b1;
        tick();
        left_btn = 1'b0;
        if (!inw) begin
            check("oow_busy", 196'(busy), 196'(0));
            repeat (3) tick();
            check("oow_img", img, model_img);
            return;
        end
        col     = (x - 90) / 10;
        row     = (y - 34) / 14;
        idx     = row * 14 + col;
        k       = (col > row) ? col : row;
        new_bit = !model_img[idx];
        n_busy  = 0;
        edges   = 1;
        lat     = 0;
        while (busy && n_busy < 40) begin
            n_busy++;
            tick();
            edges++;
            if (lat == 0 && img[idx]) lat = edges;
        end
        model_img[idx] = 1'b1;
        check("paint_busy_cycles", 196'(n_busy), 196'(k + 2));
        if (new_bit) check("paint_latency", 196'(lat), 196'(k + 3));
        check("paint_img", img, model_img);
    endtask

    task automatic submit(input int n_wait, input logic [3:0] d);
        int nvalid;
        submit_btn = 1'b1;
        tick();
        submit_btn   = 1'b0;
        model_dvalid = 1'b0;
        check("submit_dvalid_clr", 196'(digit_valid), 196'(0));
        nvalid = 0;
        for (int i = 0; i < n_wait; i++) begin
            if (img_valid) nvalid++;
            check("send_img_frozen", img, model_img);
            tick();
        end
        nn_ready = 1'b1;
        if (img_valid) nvalid++;
        tick();
        nn_ready = 1'b0;
        check("send_valid_cycles", 196'(nvalid), 196'(n_wait + 1));
        check("send_valid_drop", 196'(img_valid), 196'(0));
        check("wait_busy", 196'(busy), 196'(1));
        mouse_x   = 9'd100;
        mouse_y   = 9'd50;
        left_btn  = 1'b1;
        clear_btn = 1'b1;
        repeat (2) tick();
        left_btn  = 1'b0;
        clear_btn = 1'b0;
        tick();
        check("wait_img_frozen", img, model_img);
        check("wait_still_busy", 196'(busy), 196'(1));
        nn_digit = d;
        nn_done  = 1'b1;
        tick();
        nn_done      = 1'b0;
        nn_digit     = 4'd0;
        model_digit  = d;
        model_dvalid = 1'b1;
        check("done_digit", 196'(digit_out), 196'(model_digit));
        check("done_dvalid", 196'(digit_valid), 196'(model_dvalid));
        check("done_idle", 196'(busy), 196'(0));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 196'(busy), 196'(0));
        check({tag, "_img"}, img, 196'(0));
        check({tag, "_img_valid"}, 196'(img_valid), 196'(0));
        check({tag, "_digit_valid"}, 196'(digit_valid), 196'(0));
        check({tag, "_digit_out"}, 196'(digit_out), 196'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mouse_x = 9'd0; mouse_y = 9'd0; left_btn = 1'b0;
        clear_btn = 1'b0; submit_btn = 1'b0; nn_ready = 1'b0; nn_done = 1'b0;
        nn_digit = 4'd0; model_img = '0; model_digit = 4'd0; model_dvalid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        check_reset_state("reset");

        click(90, 34);
        click(229, 215);
        click(230, 100);
        click(89, 50);
        click(229, 229);

        // Clear rising edge wins over a simultaneous in-window paint.
        mouse_x = 9'd150; mouse_y = 9'd100; left_btn = 1'b1; clear_btn = 1'b1;
        tick();
        left_btn = 1'b0;
        model_img = '0;
        check("clear_no_paint_busy", 196'(busy), 196'(0));
        check("clear_img", img, model_img);
        clear_btn = 1'b0;
        tick();

        for (int i = 0; i < 25; i++)
            click(int'($urandom_range(80, 240)), int'($urandom_range(24, 240)));

        submit(3, 4'd7);

        nn_digit = 4'd2; nn_done = 1'b1;
        tick();
        nn_done = 1'b0;
        check("idle_done_ignored", 196'(digit_out), 196'(model_digit));
        click(120, 60);
        check("dvalid_holds", 196'(digit_valid), 196'(1));

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++)
                click(int'($urandom_range(85, 235)), int'($urandom_range(30, 235)));
            submit(int'($urandom_range(0, 5)), 4'($urandom_range(0, 15)));
        end

        clear_btn = 1'b1;
        tick();
        clear_btn = 1'b0;
        model_img = '0;
        model_dvalid = 1'b0;
        check("clear_dvalid", 196'(digit_valid), 196'(0));
        check("clear_img2", img, model_img);

        click(150, 150);
        mouse_x = 9'd229; mouse_y = 9'd215; left_btn = 1'b1;
        tick();
        left_btn = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_img = '0;
        check_reset_state("rst_in_map");

        click(100, 40);
        submit_btn = 1'b1;
        tick();
        submit_btn = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_img = '0;
        check_reset_state("rst_in_send");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
